// File: rtl/next_pc_ctrl_pkg.sv
// Shared opcode constants, address limits and FSM state type for the
// next-PC controller and its target mux.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_MOV56 = 6'd56;
    localparam logic [5:0] OP_MOV57 = 6'd57;
    localparam logic [5:0] OP_MOV58 = 6'd58;
    localparam logic [5:0] FUNCT_JR = 6'd8;

    localparam logic [31:0] PC_LIMIT = 32'd32764;
    localparam logic [31:0] MEM_TOP  = 32'd32764;
    localparam logic [31:0] RESET_PC = 32'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // Move addresses up to and including MEM_TOP are data memory; above is I/O.
    function automatic logic is_mem_addr(input logic [15:0] addr);
        return ({16'd0, addr} <= MEM_TOP);
    endfunction

endpackage

// File: rtl/next_pc_ctrl_if.sv
// Instruction-side bundle between the fetch/decode stage and the next-PC controller.
interface next_pc_ctrl_if;

    logic [31:0] pc;
    logic [5:0]  op_code;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] jtarget;
    logic [31:0] rs_data;
    logic        br_taken;
    logic [15:0] move_data;
    logic [31:0] pc_next;
    logic        stall;
    logic        halt;

    modport master (
        output pc, op_code, funct, imm16, jtarget, rs_data, br_taken, move_data,
        input  pc_next, stall, halt
    );

    modport slave (
        input  pc, op_code, funct, imm16, jtarget, rs_data, br_taken, move_data,
        output pc_next, stall, halt
    );

endinterface

// File: rtl/next_pc_ctrl_pc_target_calc.sv
// Combinational non-stalled target: sequential, taken branch, jump or jump-register.
module pc_target_calc
    import mips_pkg::*;
(
    input  logic [31:0] i_pc4,
    input  logic [5:0]  i_op_code,
    input  logic [5:0]  i_funct,
    input  logic [15:0] i_imm16,
    input  logic [25:0] i_jtarget,
    input  logic [31:0] i_rs_data,
    input  logic        i_br_taken,
    output logic [31:0] o_target
);

    logic [31:0] w_br_offset;

    assign w_br_offset = {{14{i_imm16[15]}}, i_imm16, 2'b00};

    // Target selection; br_taken only matters for the two branch opcodes.
    always_comb begin
        o_target = i_pc4;
        case (i_op_code)
            OP_BEQ, OP_BNE: begin
                if (i_br_taken) begin
                    o_target = i_pc4 + w_br_offset;
                end else begin
                    o_target = i_pc4;
                end
            end
            OP_J, OP_JAL: begin
                o_target = {i_pc4[31:28], i_jtarget, 2'b00};
            end
            OP_RTYPE: begin
                if (i_funct == FUNCT_JR) begin
                    o_target = i_rs_data;
                end else begin
                    o_target = i_pc4;
                end
            end
            default: begin
                o_target = i_pc4;
            end
        endcase
    end

endmodule

// File: rtl/next_pc_ctrl.sv
// Next-PC selection plus stall sequencing for the multi-cycle move opcodes
// and a sticky halt once the program-space limit is reached.
module next_pc_ctrl
    import mips_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    next_pc_ctrl_if.slave bus
);

    state_e      r_state;
    logic [1:0]  r_cnt;
    logic        r_mem_pending;
    logic        r_halt;

    logic [31:0] w_pc4;
    logic [31:0] w_target;
    logic [31:0] w_pc_next;
    logic        w_stall;
    logic        w_is_move;
    logic [1:0]  w_cnt_load;
    logic        w_mem_pending_nxt;
    logic        w_limit_hit;

    assign w_pc4 = bus.pc + 32'd4;

    pc_target_calc u_target (
        .i_pc4      (w_pc4),
        .i_op_code  (bus.op_code),
        .i_funct    (bus.funct),
        .i_imm16    (bus.imm16),
        .i_jtarget  (bus.jtarget),
        .i_rs_data  (bus.rs_data),
        .i_br_taken (bus.br_taken),
        .o_target   (w_target)
    );

    // Move decode: wait-count to load (K-1) and the updated memory-pending flag.
    always_comb begin
        w_is_move         = 1'b0;
        w_cnt_load        = 2'd0;
        w_mem_pending_nxt = r_mem_pending;
        case (bus.op_code)
            OP_MOV56: begin
                w_is_move = 1'b1;
            end
            OP_MOV57: begin
                w_is_move         = 1'b1;
                w_cnt_load        = 2'd2;
                w_mem_pending_nxt = r_mem_pending | is_mem_addr(bus.move_data);
            end
            OP_MOV58: begin
                w_is_move         = 1'b1;
                w_mem_pending_nxt = 1'b0;
                if (r_mem_pending && is_mem_addr(bus.move_data)) begin
                    w_cnt_load = 2'd2;
                end else begin
                    w_cnt_load = 2'd0;
                end
            end
            default: begin
                w_is_move = 1'b0;
            end
        endcase
    end

    // Same-cycle pc_next/stall from state and inputs; reset forces the boot address.
    always_comb begin
        w_pc_next = bus.pc;
        w_stall   = 1'b1;
        if (rst) begin
            w_pc_next = RESET_PC;
            w_stall   = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_is_move) begin
                        w_pc_next = bus.pc;
                        w_stall   = 1'b1;
                    end else begin
                        w_pc_next = w_target;
                        w_stall   = 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt != 2'd0) begin
                        w_pc_next = bus.pc;
                        w_stall   = 1'b1;
                    end else begin
                        w_pc_next = w_pc4;
                        w_stall   = 1'b0;
                    end
                end
                ST_HALT: begin
                    w_pc_next = bus.pc;
                    w_stall   = 1'b1;
                end
                default: begin
                    w_pc_next = bus.pc;
                    w_stall   = 1'b1;
                end
            endcase
        end
    end

    assign w_limit_hit = ~w_stall & (w_pc_next >= PC_LIMIT);

    // Control FSM: move wait counting, memory-pending tracking and sticky halt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 2'd0;
            r_mem_pending <= 1'b0;
            r_halt        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_is_move) begin
                        r_state       <= ST_WAIT;
                        r_cnt         <= w_cnt_load;
                        r_mem_pending <= w_mem_pending_nxt;
                    end else if (w_limit_hit) begin
                        r_state <= ST_HALT;
                        r_halt  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt != 2'd0) begin
                        r_cnt <= r_cnt - 2'd1;
                    end else if (w_limit_hit) begin
                        r_state <= ST_HALT;
                        r_halt  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_HALT: begin
                    r_halt <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.pc_next = w_pc_next;
    assign bus.stall   = w_stall;
    assign bus.halt    = r_halt;

endmodule

// File: tb/tb_next_pc_ctrl.sv
// Self-checking bench: directed scenarios then randomized cycles against a
// cycle-level reference model of the next-PC rules.
module tb_next_pc_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    next_pc_ctrl_if bus();

    next_pc_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    bit m_halted;
    bit m_in_move;
    int m_hold;
    bit m_mem_pending;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int move_wait_cycles(input int op, input int md, input bit mp);
        if (op == 56) return 1;
        if (op == 57) return 3;
        if (mp && md <= 32764) return 3;
        return 1;
    endfunction

    task automatic run_cycle(input bit r, input logic [31:0] pcv, input int op, input int fn,
                             input logic [15:0] imm, input logic [25:0] jt,
                             input logic [31:0] rs, input bit br, input logic [15:0] md);
        logic [31:0] pc4;
        logic [31:0] exp_next;
        bit          exp_stall;
        bit          exp_halt;
        bit          is_move;
        int          off;
        @(negedge clk);
        rst           = r;
        bus.pc        = pcv;
        bus.op_code   = 6'(op);
        bus.funct     = 6'(fn);
        bus.imm16     = imm;
        bus.jtarget   = jt;
        bus.rs_data   = rs;
        bus.br_taken  = br;
        bus.move_data = md;
        #2;
        pc4     = pcv + 32'd4;
        is_move = (op >= 56 && op <= 58);
        off     = $signed(imm);
        if (r) begin
            exp_next = 32'd0; exp_stall = 1'b0; exp_halt = 1'b0;
        end else begin
            exp_halt = m_halted;
            if (m_halted) begin
                exp_next = pcv; exp_stall = 1'b1;
            end else if (m_in_move) begin
                exp_stall = (m_hold > 0);
                exp_next  = exp_stall ? pcv : pc4;
            end else if (is_move) begin
                exp_next = pcv; exp_stall = 1'b1;
            end else begin
                exp_stall = 1'b0;
                if ((op == 4 || op == 5) && br) exp_next = pc4 + 32'(off * 4);
                else if (op == 2 || op == 3)    exp_next = {pc4[31:28], jt, 2'b00};
                else if (op == 0 && fn == 8)    exp_next = rs;
                else                            exp_next = pc4;
            end
        end
        check_eq("pc_next", bus.pc_next, exp_next);
        check_eq("stall", 32'(bus.stall), 32'(exp_stall));
        check_eq("halt", 32'(bus.halt), 32'(exp_halt));
        @(posedge clk);
        if (r) begin
            m_halted = 0; m_in_move = 0; m_hold = 0; m_mem_pending = 0;
        end else if (m_halted) begin
            m_halted = 1;
        end else if (m_in_move) begin
            if (m_hold > 0) begin
                m_hold--;
            end else begin
                m_in_move = 0;
                if (exp_next >= 32'd32764) m_halted = 1;
            end
        end else if (is_move) begin
            m_hold    = move_wait_cycles(op, int'(md), m_mem_pending) - 1;
            m_in_move = 1;
            if (op == 57 && md <= 16'd32764) m_mem_pending = 1;
            if (op == 58) m_mem_pending = 0;
        end else if (exp_next >= 32'd32764) begin
            m_halted = 1;
        end
    endtask

    // Run n idle-ish cycles presenting the same instruction (used while stalled).
    task automatic repeat_op(input int n, input logic [31:0] pcv, input int op, input logic [15:0] md);
        for (int i = 0; i < n; i++) run_cycle(1'b0, pcv, op, 0, 16'd0, 26'd0, 32'd0, 1'b0, md);
    endtask

    initial begin
        int ops[10] = '{0, 2, 3, 4, 5, 8, 56, 57, 58, 35};
        n_checks = 0; n_errors = 0;
        m_halted = 0; m_in_move = 0; m_hold = 0; m_mem_pending = 0;
        rst = 1'b1;
        // Reset state
        run_cycle(1'b1, 32'h100, 8, 0, 16'd0, 26'd0, 32'd0, 1'b0, 16'd0);
        run_cycle(1'b1, 32'h100, 8, 0, 16'd0, 26'd0, 32'd0, 1'b0, 16'd0);
        // Sequential, branches, jump, jr
        run_cycle(1'b0, 32'h100, 8, 0, 16'd0, 26'd0, 32'd0, 1'b0, 16'd0);
        run_cycle(1'b0, 32'h200, 4, 0, 16'hFFFE, 26'd0, 32'd0, 1'b1, 16'd0);
        run_cycle(1'b0, 32'h200, 4, 0, 16'hFFFE, 26'd0, 32'd0, 1'b0, 16'd0);
        run_cycle(1'b0, 32'h40, 2, 0, 16'd0, 26'h10, 32'd0, 1'b1, 16'd0);
        run_cycle(1'b0, 32'h40, 0, 8, 16'd0, 26'd0, 32'h300, 1'b0, 16'd0);
        run_cycle(1'b0, 32'h40, 9, 8, 16'd0, 26'd0, 32'h300, 1'b1, 16'd0);
        // Moves: 56 (K=1), 57 to memory (K=3), 58 pending (K=3), repeated 58 (K=1)
        repeat_op(2, 32'h20, 56, 16'h0);
        repeat_op(4, 32'h24, 57, 16'h100);
        repeat_op(4, 32'h28, 58, 16'h80);
        repeat_op(2, 32'h2C, 58, 16'h80);
        // Boundary move_data: 32764 is memory, 32765 is I/O
        repeat_op(4, 32'h30, 57, 16'd32765);
        repeat_op(2, 32'h34, 58, 16'd32764);
        repeat_op(4, 32'h38, 57, 16'd32764);
        repeat_op(4, 32'h3C, 58, 16'd32764);
        // Reset mid-WAIT of a 57, then 58 takes K=1
        repeat_op(2, 32'h50, 57, 16'h100);
        run_cycle(1'b1, 32'h50, 57, 0, 16'd0, 26'd0, 32'd0, 1'b0, 16'h100);
        repeat_op(2, 32'h50, 58, 16'h80);
        // Limit halt, sticky until reset
        run_cycle(1'b0, 32'd32760, 8, 0, 16'd0, 26'd0, 32'd0, 1'b0, 16'd0);
        repeat_op(3, 32'd32764, 8, 16'd0);
        run_cycle(1'b1, 32'd32764, 8, 0, 16'd0, 26'd0, 32'd0, 1'b0, 16'd0);
        // Negative branch below 0 wraps and halts
        run_cycle(1'b0, 32'h0, 5, 0, 16'hFFF0, 26'd0, 32'd0, 1'b1, 16'd0);
        repeat_op(2, 32'h0, 8, 16'd0);
        run_cycle(1'b1, 32'h0, 8, 0, 16'd0, 26'd0, 32'd0, 1'b0, 16'd0);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] pcv;
            bit          r;
            if ($urandom_range(0, 9) == 0) pcv = 32'(32740 + 4 * $urandom_range(0, 5));
            else                           pcv = 32'($urandom_range(0, 16'h1C00)) << 2;
            r = ($urandom_range(0, 39) == 0) || (m_halted && $urandom_range(0, 2) == 0);
            run_cycle(r, pcv, ops[$urandom_range(0, 9)], int'($urandom_range(0, 15)),
                      16'($urandom), 26'($urandom_range(0, 26'h1FFF)),
                      32'($urandom_range(0, 16'h7FFF)) & 32'hFFFF_FFFC,
                      1'($urandom), 16'($urandom_range(16'd32700, 16'd32830)));
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/next_pc_ctrl.md
# next_pc_ctrl

Next-PC and stall controller feeding the program counter's `pcin`. It computes the address of the next instruction: sequential (+4), branch, jump, jump-register. It also owns the multi-cycle stall sequencing for the move opcodes 56/57/58, holding the PC for the required number of cycles. A sticky halt is raised when the computed address reaches the program-space limit.

## Interface
- `PC_LIMIT`, 32764: first illegal byte address; `pc_next` ≥ this raises halt.
- `MEM_TOP`, 32764 (8191*4): `move_data` ≤ this is memory space, > is I/O space.
- `RESET_PC`, 0: value driven on `pc_next` during reset.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pc`  in  32  current PC (register output).
- `op_code`  in  6  opcode of the instruction at `pc`.
- `funct`  in  6  R-type function field.
- `imm16`  in  16  branch offset (words, signed).
- `jtarget`  in  26  J-type target field.
- `rs_data`  in  32  register value for `jr`.
- `br_taken`  in  1  ALU compare result (equal for beq, not-equal for bne).
- `move_data`  in  16  source/destination byte address of a move.
- `pc_next`  out  32  address to load into the PC next edge.
- `stall`  out  1  PC must hold; decode must not retire.
- `halt`  out  1  sticky program-end flag.

## Operation
- States: IDLE, WAIT, HALT. Registers: `state`, 2-bit `cnt`, `mem_pending`, `halt`.
- `pc4 = pc + 4` mod 2^32.
- Sign-extend `imm16` before shifting.
- IDLE target selection:
  - beq (4) / bne (5) with `br_taken`=1 → `pc4 + (sext(imm16)<<2)`.
  - j (2) / jal (3) → `{pc4[31:28], jtarget, 2'b00}`.
  - op 0 and funct 8 → `rs_data`.
  - Otherwise → `pc4`.
- IDLE move opcodes set `stall`=1, `pc_next`=`pc`, load `cnt`=K−1, and go to WAIT:
  - 56: K=1.
  - 57: K=3; if `move_data` ≤ MEM_TOP, set `mem_pending`=1.
  - 58: K=3 if `mem_pending` and `move_data` ≤ MEM_TOP, else K=1; clear `mem_pending`.
- WAIT ignores `op_code` (same instruction re-presented):
  - `cnt`≠0 → `stall`=1, `pc_next`=`pc`, decrement `cnt`.
  - `cnt`=0 → `stall`=0, `pc_next`=`pc4`, go to IDLE.
- Halt check applies to every non-stalled `pc_next` (IDLE or WAIT exit):
  - If `pc_next` ≥ PC_LIMIT (unsigned), the next state is HALT and `halt` is 1 from the next edge.
  - The offending `pc_next` is still driven that cycle; the PC register gates on `halt`.
- HALT: `stall`=1, `pc_next`=`pc`. Sticky until `rst`.

## Timing
- `pc_next`/`stall` are combinational from inputs and state (same cycle). `halt`/state/`cnt`/`mem_pending` are registered.
- Move op with K wait cycles: PC held K edges, advances to `pc+4` on edge K+1.
- Reset (any state, including mid-WAIT):
  - Registers: state=IDLE, `cnt`=0, `mem_pending`=0, `halt`=0.
  - Outputs while `rst`: `pc_next`=RESET_PC, `stall`=0.
- Negative branch below 0 wraps mod 2^32 → ≥ PC_LIMIT → halt.
- `move_data`=32764 exactly counts as memory; 32765 counts as I/O.
- Op 58 with no preceding 57 (`mem_pending`=0): K=1.
- `br_taken` ignored for non-branch opcodes.

## Structure
- Shared package `mips_pkg`:
  - Opcode constants OP_RTYPE=0, OP_J=2, OP_JAL=3, OP_BEQ=4, OP_BNE=5, OP_MOV56=56, OP_MOV57=57, OP_MOV58=58, FUNCT_JR=8.
  - State enum.
- Sub-module `pc_target_calc`: combinational branch/jump/jr target mux. The FSM lives in `next_pc_ctrl`.

## Test plan
- Sequential: `pc`=0x100, op 8 → `pc_next`=0x104, `stall`=0.
- Branch: `pc`=0x200, beq, `imm16`=0xFFFE, `br_taken`=1 → 0x1FC. Same with `br_taken`=0 → 0x204.
- Jump/jr: `pc`=0x40, j, `jtarget`=0x10 → 0x40. Op 0 funct 8, `rs_data`=0x300 → 0x300.
- Moves:
  - Op 56 at 0x20 → `stall` 1 for 1 cycle, then `pc_next`=0x24.
  - Op 57 `move_data`=0x100 → 3 stall cycles, `mem_pending`=1.
  - Then op 58 `move_data`=0x80 → 3 stall cycles. Repeated op 58 → 1 cycle.
- Limit: `pc`=32760, op 8 → `pc_next`=32764; `halt`=1 next edge and stays 1 with `stall`=1 until `rst`.
- Reset mid-WAIT during op 57 → IDLE, `stall`=0, `pc_next`=0; next op 58 takes K=1.
